// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl_pkg
// Description : Shared cell, turn and board types for the tic-tac-toe
//               controller, plus a cell-extraction helper.
// Revision    : 1.0 - initial release
// ============================================================================
package game_ctrl_pkg;

   // One 2-bit cell value (blank / X / O)
   typedef logic [1:0]  STATE_T;
   // Nine cells, cell i at bits [2i+1:2i]
   typedef logic [17:0] BOARD_T;
   // Cell index 0..8 (values 9..15 are illegal requests)
   typedef logic [3:0]  INDEX_T;
   typedef logic        FLAG_T;

   localparam STATE_T CELL_BLANK  = 2'b00;
   localparam STATE_T CELL_X      = 2'b01;
   localparam STATE_T CELL_O      = 2'b10;

   localparam FLAG_T  TURN_PLAYER = 1'b0;
   localparam FLAG_T  TURN_AI     = 1'b1;

   // Returns the cell at idx; only meaningful for idx <= 8
   function automatic STATE_T get_cell(input BOARD_T b, input INDEX_T idx);
      return STATE_T'(b >> {idx, 1'b0});
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl_if
// Description : Move-request and game-status bundle between the players and
//               the game controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_ctrl_if;
   import game_ctrl_pkg::*;

   INDEX_T   p_loc;
   FLAG_T    p_submit;
   INDEX_T   a_loc;
   STATE_T   a_val;
   FLAG_T    a_submit;
   FLAG_T    game_reset;
   BOARD_T   board_state;
   FLAG_T    turn;
   FLAG_T    game_over;
   STATE_T   winner;
   logic [3:0] move_count;
   FLAG_T    err;

   // Side issuing moves and reading status
   modport master (
      output p_loc, p_submit, a_loc, a_val, a_submit, game_reset,
      input  board_state, turn, game_over, winner, move_count, err
   );

   // Game controller side
   modport slave (
      input  p_loc, p_submit, a_loc, a_val, a_submit, game_reset,
      output board_state, turn, game_over, winner, move_count, err
   );

endinterface
`default_nettype wire

// File: rtl/line_check_m.sv
`default_nettype none
// ============================================================================
// Module      : line_check_m
// Description : Combinational three-in-a-row detector for one symbol over
//               the 8 lines (3 rows, 3 columns, 2 diagonals).
// Revision    : 1.0 - initial release
// ============================================================================
module line_check_m
   import game_ctrl_pkg::*;
(
   input  BOARD_T i_board,
   input  STATE_T i_symbol,
   output FLAG_T  o_win
);

   logic [8:0] w_hit;

   // Per-cell match against the symbol under test
   generate
      for (genvar g = 0; g < 9; g++) begin : g_cell
         assign w_hit[g] = (i_board[2*g +: 2] == i_symbol);
      end
   endgenerate

   assign o_win = (w_hit[0] & w_hit[1] & w_hit[2]) |
                  (w_hit[3] & w_hit[4] & w_hit[5]) |
                  (w_hit[6] & w_hit[7] & w_hit[8]) |
                  (w_hit[0] & w_hit[3] & w_hit[6]) |
                  (w_hit[1] & w_hit[4] & w_hit[7]) |
                  (w_hit[2] & w_hit[5] & w_hit[8]) |
                  (w_hit[0] & w_hit[4] & w_hit[8]) |
                  (w_hit[2] & w_hit[4] & w_hit[6]);

endmodule
`default_nettype wire

// File: rtl/game_ctrl_m.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl_m
// Description : Tic-tac-toe referee. Validates alternating player/AI moves,
//               writes the board, detects wins/draws and forfeits an idle AI.
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl_m
   import game_ctrl_pkg::*;
#(
   parameter int AI_TIMEOUT   = 64,
   parameter int PLAYER_FIRST = 1
)(
   input  logic         clk,
   input  logic         rst,
   game_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      P_TURN = 2'd0,
      A_TURN = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } fsm_t;

   // Timeout counter holds 0..AI_TIMEOUT-1; the last value is the forfeit cycle
   localparam int            TW         = (AI_TIMEOUT > 1) ? $clog2(AI_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(AI_TIMEOUT - 1);
   localparam fsm_t          START_ST   = (PLAYER_FIRST != 0) ? P_TURN : A_TURN;
   localparam FLAG_T         START_TURN = (PLAYER_FIRST != 0) ? TURN_PLAYER : TURN_AI;

   fsm_t          r_state, w_state_nxt;
   BOARD_T        r_board;
   STATE_T        r_winner;
   logic [3:0]    r_count;
   FLAG_T         r_turn, r_game_over, r_err, r_p_prev, r_a_prev;
   logic [TW-1:0] r_tmo;

   FLAG_T  w_p_req, w_a_req, w_req, w_loc_ok, w_blank, w_val_ok;
   FLAG_T  w_accept, w_reject, w_win, w_full, w_tmo_hit;
   INDEX_T w_loc;
   STATE_T w_sym;

   // r_turn always names the side that owns the current move (also in CHECK)
   assign w_sym     = (r_turn == TURN_AI) ? CELL_O : CELL_X;
   assign w_loc     = (r_turn == TURN_AI) ? bus.a_loc : bus.p_loc;

   assign w_p_req   = bus.p_submit & ~r_p_prev;
   assign w_a_req   = bus.a_submit & ~r_a_prev;
   assign w_req     = ((r_state == P_TURN) & w_p_req) | ((r_state == A_TURN) & w_a_req);
   assign w_loc_ok  = (w_loc <= 4'd8);
   assign w_blank   = (get_cell(r_board, w_loc) == CELL_BLANK);
   assign w_val_ok  = (r_state != A_TURN) || (bus.a_val == CELL_O);
   assign w_accept  = w_req & w_loc_ok & w_blank & w_val_ok;
   assign w_reject  = w_req & ~(w_loc_ok & w_blank & w_val_ok);
   assign w_full    = (r_count == 4'd9);
   assign w_tmo_hit = (r_state == A_TURN) & ~w_accept & (r_tmo == TMO_LAST);

   line_check_m u_line_check (
      .i_board  (r_board),
      .i_symbol (w_sym),
      .o_win    (w_win)
   );

   // State register; a new game restarts from the configured opener
   always_ff @(posedge clk) begin
      if (rst || bus.game_reset) r_state <= START_ST;
      else                       r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         P_TURN, A_TURN: begin
            if (w_accept)       w_state_nxt = CHECK;
            else if (w_tmo_hit) w_state_nxt = DONE;
         end
         CHECK: begin
            if (w_win || w_full)        w_state_nxt = DONE;
            else if (r_turn == TURN_AI) w_state_nxt = P_TURN;
            else                        w_state_nxt = A_TURN;
         end
         default: w_state_nxt = r_state;
      endcase
   end

   // Board, counters, result flags and submit edge history
   always_ff @(posedge clk) begin
      if (rst || bus.game_reset) begin
         r_board     <= '0;
         r_count     <= 4'd0;
         r_winner    <= CELL_BLANK;
         r_game_over <= 1'b0;
         r_err       <= 1'b0;
         r_tmo       <= '0;
         r_turn      <= START_TURN;
         // Load current levels so a submit held across a reset is not an edge
         r_p_prev    <= bus.p_submit;
         r_a_prev    <= bus.a_submit;
      end else begin
         r_p_prev <= bus.p_submit;
         r_a_prev <= bus.a_submit;
         r_err    <= w_reject;
         if (w_accept) begin
            for (int i = 0; i < 9; i++) begin
               if (w_loc == INDEX_T'(i)) r_board[2*i +: 2] <= w_sym;
            end
            r_count <= r_count + 4'd1;
         end
         // Rejected AI requests keep the clock running
         if ((r_state == A_TURN) && !w_accept) r_tmo <= r_tmo + TW'(1);
         if (w_tmo_hit) begin
            r_winner    <= CELL_X;
            r_game_over <= 1'b1;
         end
         if (r_state == CHECK) begin
            r_tmo <= '0;
            if (w_win) begin
               r_winner    <= w_sym;
               r_game_over <= 1'b1;
            end else if (w_full) begin
               r_game_over <= 1'b1;
            end else begin
               r_turn <= ~r_turn;
            end
         end
      end
   end

   assign bus.board_state = r_board;
   assign bus.turn        = r_turn;
   assign bus.game_over   = r_game_over;
   assign bus.winner      = r_winner;
   assign bus.move_count  = r_count;
   assign bus.err         = r_err;

endmodule
`default_nettype wire
